// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack for the fetch predictor.
// Circular buffer of RAS_ENTRIES return targets with push, pop, pop-then-push
// (replace top), and a one-cycle restore of ptr/count from a checkpoint.
// Optional feature macro: RAS_TOP_REPAIR_EN -- when defined, a restore also
// rewrites array[restore_ptr] with restore_top_target.
module ras_ckpt #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_ptr,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    input  logic [RAS_TARGET_WIDTH-1:0] restore_top_target,
    output logic                        top_valid,
    output logic [RAS_TARGET_WIDTH-1:0] top_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ckpt_ptr,
    output logic [RAS_INDEX_WIDTH:0]    ckpt_count,
    output logic [RAS_TARGET_WIDTH-1:0] ckpt_top_target,
    output logic                        underflow
);

    localparam logic [RAS_INDEX_WIDTH:0]   FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH-1:0] ONE  = RAS_INDEX_WIDTH'(1);
    localparam logic [RAS_INDEX_WIDTH:0]   CONE = (RAS_INDEX_WIDTH+1)'(1);

    logic [RAS_TARGET_WIDTH-1:0] mem_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [RAS_INDEX_WIDTH:0]    count_q, count_d;
    logic                        underflow_q, underflow_d;

    // Single array write port, shared by push, replace-top and top repair
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
    logic [RAS_TARGET_WIDTH-1:0] wr_data;

    logic non_empty;
    assign non_empty = (count_q != '0);

`ifndef RAS_TOP_REPAIR_EN
    // Checkpointed top target only matters when top repair is built in
    logic unused_restore_top;
    assign unused_restore_top = ^restore_top_target;
`endif

    // Next-state selection: restore > push+pop > push > pop > idle
    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ptr_q;
        wr_data     = push_target;
        if (restore_valid) begin
            ptr_d   = restore_ptr;
            count_d = restore_count;
`ifdef RAS_TOP_REPAIR_EN
            wr_en   = 1'b1;
            wr_idx  = restore_ptr;
            wr_data = restore_top_target;
`endif
        end else if (push_valid && pop_valid && non_empty) begin
            // Replace top: pointer and occupancy stay put
            wr_en = 1'b1;
        end else if (push_valid) begin
            // Also covers push+pop on an empty stack. When full the
            // write lands on the oldest entry, which is simply lost.
            ptr_d  = ptr_q + ONE;
            wr_en  = 1'b1;
            wr_idx = ptr_q + ONE;
            if (count_q != FULL) count_d = count_q + CONE;
        end else if (pop_valid) begin
            if (non_empty) begin
                ptr_d   = ptr_q - ONE;
                count_d = count_q - CONE;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    // Pointer, occupancy and underflow pulse registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Target storage, cleared on reset so the top reads 0 when empty
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign top_valid       = non_empty;
    assign top_target      = mem_q[ptr_q];
    assign ckpt_ptr        = ptr_q;
    assign ckpt_count      = count_q;
    assign ckpt_top_target = mem_q[ptr_q];
    assign underflow       = underflow_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed scenarios with literal
// expectations, then randomized push/pop/restore traffic against a
// behavioural stack model compared every cycle.
module tb_ras_ckpt;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 31;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          push_valid = 1'b0;
    logic [TW-1:0] push_target = '0;
    logic          pop_valid = 1'b0;
    logic          restore_valid = 1'b0;
    logic [IW-1:0] restore_ptr = '0;
    logic [IW:0]   restore_count = '0;
    logic [TW-1:0] restore_top_target = '0;
    logic          top_valid;
    logic [TW-1:0] top_target;
    logic [IW-1:0] ckpt_ptr;
    logic [IW:0]   ckpt_count;
    logic [TW-1:0] ckpt_top_target;
    logic          underflow;

    ras_ckpt #(.RAS_ENTRIES(N), .RAS_INDEX_WIDTH(IW), .RAS_TARGET_WIDTH(TW)) dut (
        .CLK(CLK), .nRST(nRST),
        .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
        .restore_valid(restore_valid), .restore_ptr(restore_ptr),
        .restore_count(restore_count), .restore_top_target(restore_top_target),
        .top_valid(top_valid), .top_target(top_target), .ckpt_ptr(ckpt_ptr),
        .ckpt_count(ckpt_count), .ckpt_top_target(ckpt_top_target), .underflow(underflow)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a stack living in a ring of N slots
    int m_arr [N];
    int m_ptr, m_cnt, m_uf;

`ifdef RAS_TOP_REPAIR_EN
    localparam bit REPAIR = 1'b1;
`else
    localparam bit REPAIR = 1'b0;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_arr[i] = 0;
        m_ptr = 0; m_cnt = 0; m_uf = 0;
    endtask

    task automatic model_step();
        m_uf = 0;
        if (restore_valid) begin
            if (REPAIR) m_arr[restore_ptr] = int'(restore_top_target);
            m_ptr = int'(restore_ptr);
            m_cnt = int'(restore_count);
        end else if (push_valid && pop_valid && m_cnt > 0) begin
            m_arr[m_ptr] = int'(push_target);
        end else if (push_valid) begin
            m_ptr = (m_ptr + 1) % N;
            m_arr[m_ptr] = int'(push_target);
            if (m_cnt < N) m_cnt++;
        end else if (pop_valid) begin
            if (m_cnt > 0) begin
                m_ptr = (m_ptr + N - 1) % N;
                m_cnt--;
            end else begin
                m_uf = 1;
            end
        end
    endtask

    // One clock: drive, commit at the rising edge, return at the falling edge
    task automatic cyc(input bit pv, input int pt, input bit ppv, input bit rv,
                       input int rp, input int rc, input int rt);
        push_valid = pv; push_target = TW'(pt); pop_valid = ppv;
        restore_valid = rv; restore_ptr = IW'(rp); restore_count = (IW+1)'(rc);
        restore_top_target = TW'(rt);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic push(input int t); cyc(1, t, 0, 0, 0, 0, 0); endtask
    task automatic pop();             cyc(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic pushpop(input int t); cyc(1, t, 1, 0, 0, 0, 0); endtask
    task automatic idle();            cyc(0, 0, 0, 0, 0, 0, 0); endtask

    // Async reset pulse between edges; released on a falling edge
    task automatic rst_pulse();
        #2 nRST = 1'b0;
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        push_valid = 0; pop_valid = 0; restore_valid = 0;
    endtask

    // Illegal checkpoint occupancy must never be presented
    always @(posedge CLK)
        if (nRST && restore_valid)
            assert (restore_count <= N) else $error("restore_count %0d exceeds depth", restore_count);

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en && nRST) begin
            check("top_valid", top_valid, m_cnt != 0);
            check("top_target", top_target, m_arr[m_ptr]);
            check("ckpt_ptr", ckpt_ptr, m_ptr);
            check("ckpt_count", ckpt_count, m_cnt);
            check("ckpt_top_target", ckpt_top_target, m_arr[m_ptr]);
            check("underflow", underflow, m_uf);
        end
    end

    int snap_ptr, snap_cnt, snap_top;

    initial begin
        model_reset();
        #12;
        check("rst_top_valid", top_valid, 0);
        check("rst_top_target", top_target, 0);
        check("rst_ckpt_ptr", ckpt_ptr, 0);
        check("rst_ckpt_count", ckpt_count, 0);
        check("rst_underflow", underflow, 0);
        @(negedge CLK);
        nRST = 1'b1;
        chk_en = 1'b1;

        // Basic push/pop
        push('h100); push('h200); push('h300);
        check("tp1_top", top_target, 'h300);
        check("tp1_cnt", ckpt_count, 3);
        check("tp1_ptr", ckpt_ptr, 3);
        pop();
        check("tp1_pop_top", top_target, 'h200);
        check("tp1_pop_cnt", ckpt_count, 2);

        // Wrap on overflow, entry 1 lost
        rst_pulse();
        for (int i = 1; i <= 9; i++) push(i);
        check("tp2_cnt", ckpt_count, 8);
        check("tp2_top", top_target, 9);
        for (int i = 0; i < 7; i++) pop();
        check("tp2_top7", top_target, 2);
        pop();
        check("tp2_cnt0", ckpt_count, 0);
        check("tp2_tv0", top_valid, 0);

        // Underflow pulse on empty pop
        pop();
        check("tp3_uf", underflow, 1);
        check("tp3_ptr", ckpt_ptr, 1);
        check("tp3_cnt", ckpt_count, 0);
        idle();
        check("tp3_uf_clr", underflow, 0);

        // Replace top, and push+pop on empty
        rst_pulse();
        push('hA); pushpop('hB);
        check("tp4_top", top_target, 'hB);
        check("tp4_cnt", ckpt_count, 1);
        check("tp4_ptr", ckpt_ptr, 1);
        pop();
        pushpop('hC);
        check("tp4e_cnt", ckpt_count, 1);
        check("tp4e_top", top_target, 'hC);
        check("tp4e_uf", underflow, 0);

        // Checkpoint and restore with a conflicting push
        rst_pulse();
        push('h10); push('h20);
        snap_ptr = int'(ckpt_ptr); snap_cnt = int'(ckpt_count); snap_top = int'(ckpt_top_target);
        check("tp5_snap_ptr", snap_ptr, 2);
        check("tp5_snap_cnt", snap_cnt, 2);
        check("tp5_snap_top", snap_top, 'h20);
        push('h30); pop(); pop(); push('h99);
        cyc(1, 'h55, 0, 1, snap_ptr, snap_cnt, snap_top);
        check("tp5_ptr", ckpt_ptr, 2);
        check("tp5_cnt", ckpt_count, 2);
        check("tp5_top", top_target, REPAIR ? 'h20 : 'h99);

        // Async reset during a push
        push_valid = 1'b1; push_target = 'h77;
        #2 nRST = 1'b0;
        #1;
        check("tp6_tv_async", top_valid, 0);
        check("tp6_cnt_async", ckpt_count, 0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        check("tp6_cnt_held", ckpt_count, 0);
        push_valid = 1'b0;
        nRST = 1'b1;
        idle();
        check("tp6_cnt_after", ckpt_count, 0);
        check("tp6_top_after", top_target, 0);

        // Randomized traffic
        snap_ptr = 0; snap_cnt = 0; snap_top = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                if ($urandom_range(0, 1) == 1)
                    cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1,
                        snap_ptr, snap_cnt, snap_top);
                else
                    cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1,
                        $urandom_range(0, N - 1), $urandom_range(0, N), $urandom);
            end else if (r < 10) begin
                rst_pulse();
            end else begin
                cyc($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                    0, 0, 0, 0);
            end
            if ($urandom_range(0, 15) == 0) begin
                snap_ptr = m_ptr; snap_cnt = m_cnt; snap_top = m_arr[m_ptr];
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised return address stack for the fetch predictor pipeline. It holds RAS_ENTRIES return targets in a circular buffer, supports push, pop and combined pop-then-push per cycle, and exports its pointer/count state so the checkpoint logic can snapshot it. On a branch mispredict or flush, the saved state is restored in one cycle. It sits beside the BTB/UPCT lookup in fetch and supplies return-target predictions.

## Interface
- RAS_ENTRIES, 8, stack depth; power of two, ≥2
- RAS_INDEX_WIDTH, $clog2(RAS_ENTRIES), pointer width
- RAS_TARGET_WIDTH, 31, stored target width (PC[31:1])
- CLK  input  1  clock; all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- push_valid  input  1  push push_target this cycle
- push_target  input  RAS_TARGET_WIDTH  return target to push
- pop_valid  input  1  pop top-of-stack this cycle
- restore_valid  input  1  restore from checkpoint; overrides push/pop
- restore_ptr  input  RAS_INDEX_WIDTH  checkpointed top pointer
- restore_count  input  RAS_INDEX_WIDTH+1  checkpointed occupancy
- restore_top_target  input  RAS_TARGET_WIDTH  checkpointed top entry (used only with RAS_TOP_REPAIR_EN)
- top_valid  output  1  count != 0
- top_target  output  RAS_TARGET_WIDTH  array[ptr]
- ckpt_ptr  output  RAS_INDEX_WIDTH  current ptr, for snapshot
- ckpt_count  output  RAS_INDEX_WIDTH+1  current count, for snapshot
- ckpt_top_target  output  RAS_TARGET_WIDTH  equals top_target
- underflow  output  1  registered; pulses the cycle after a pop on empty stack

## Operation
- State: array[RAS_ENTRIES], ptr (index of top), count (0..RAS_ENTRIES), underflow register.
- Reset: all array entries 0, ptr 0, count 0, underflow 0. Outputs after reset: top_valid 0, top_target 0, ckpt_* 0.
- Priority per cycle: restore > push+pop > push > pop > idle.
- Push only: ptr ← ptr+1 mod RAS_ENTRIES; array[ptr+1] ← push_target; count ← min(count+1, RAS_ENTRIES). When full, the oldest entry is silently overwritten (wrap).
- Pop only, count>0: ptr ← ptr−1 mod RAS_ENTRIES; count ← count−1; array unchanged.
- Pop only, count==0: ptr and count are unchanged; underflow ← 1 for one cycle.
- Push+pop, count>0: array[ptr] ← push_target; ptr and count are unchanged (replace top).
- Push+pop, count==0: behaves as push only; no underflow.
- Restore: ptr ← restore_ptr; count ← restore_count; push/pop are ignored; underflow ← 0. Array contents are otherwise preserved.
- restore_count > RAS_ENTRIES is illegal; the verification bench asserts against it.
- underflow is cleared every cycle that does not qualify for it.

## Timing
- top_valid, top_target and ckpt_* are combinational from registered state, so they reflect the update made at the previous edge. No input→output combinational path.
- Push, pop and restore latency is 1 cycle: results are visible after the next rising edge.
- A push in cycle N is poppable in cycle N+1.
- Asynchronous reset mid-operation immediately returns all state to reset values, regardless of pending requests.

## Configuration
- RAS_TOP_REPAIR_EN defined: on restore, array[restore_ptr] ← restore_top_target as well, repairing a top entry clobbered by wrong-path pushes.
- RAS_TOP_REPAIR_EN undefined: restore_top_target is ignored and only ptr/count are restored. ckpt_top_target remains driven either way.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles → top_target 0x300, count 3, ptr 3; pop → top_target 0x200, count 2.
- Push 9 targets (1..9) with RAS_ENTRIES=8 → count saturates at 8, top 9; pop 7 times → top 2; 8th pop → count 0, top_valid 0 (entry 1 was lost to wrap).
- Pop on empty stack → ptr/count unchanged, underflow=1 for exactly one cycle.
- Push 0xA then push+pop with 0xB → top 0xB, count 1, ptr 1; push+pop on empty stack with 0xC → count 1, top 0xC.
- Snapshot ckpt_ptr=2/count=2/top=0x20, push 0x30, pop twice, push 0x99, then restore with push asserted the same cycle → ptr 2, count 2, push ignored. With RAS_TOP_REPAIR_EN, top 0x20; without it, top 0x99.
- Assert nRST low asynchronously between edges during a push → top_valid 0, count 0 immediately, and the push is not committed.
